matmul_cmd_ctrl: RTL and testbench

- Command sequencer in front of the 8x8 matmul unit in the vector processor.
- Accepts one matrix-multiply command per handshake and derives the four validity masks from row/column counts.
- Holds the unit's activate for the whole operation and converts the unit's result-row stream into register-file writebacks of consecutive destination registers.
- Provides abort, watchdog timeout and status so the issue stage can stall or squash cleanly.

---
 rtl/matmul_cmd_ctrl_pkg.sv | 27 ++
 rtl/matmul_mask_gen.sv | 11 +
 rtl/matmul_cmd_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_matmul_cmd_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_cmd_ctrl_pkg.sv
// rtl/matmul_cmd_ctrl_pkg.sv - shared constants, FSM encoding and count-to-mask helpers
package matmul_cmd_ctrl_pkg;

    localparam int MM_SIZE    = 8;
    localparam int MM_LOG2    = 3;
    localparam int MM_TIMEOUT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef logic [MM_LOG2:0]   mm_count_t;
    typedef logic [MM_SIZE-1:0] mm_mask_t;

    function automatic mm_count_t sat_count(input mm_count_t n);
        return (n > mm_count_t'(MM_SIZE)) ? mm_count_t'(MM_SIZE) : n;
    endfunction

    // (1<<n)-1 on the saturated count; a full shift-out yields all ones
    function automatic mm_mask_t count_to_mask(input mm_count_t n);
        mm_mask_t ones;
        ones = '1;
        return ~(ones << sat_count(n));
    endfunction

endpackage

// File: rtl/matmul_mask_gen.sv
// rtl/matmul_mask_gen.sv - saturating count to thermometer validity mask
module matmul_mask_gen
    import matmul_cmd_ctrl_pkg::*;
(
    input  mm_count_t count_i,
    output mm_mask_t  mask_o
);

    assign mask_o = count_to_mask(count_i);

endmodule

// File: rtl/matmul_cmd_ctrl.sv
// rtl/matmul_cmd_ctrl.sv - command sequencer and writeback generator for the 8x8 matmul unit
module matmul_cmd_ctrl
    import matmul_cmd_ctrl_pkg::*;
#(
    parameter int MAT_MUL_SIZE      = MM_SIZE,
    parameter int LOG2_MAT_MUL_SIZE = MM_LOG2,
    parameter int REGIDWIDTH        = 8,
    parameter int NUMLANES          = 8,
    parameter int TIMEOUT           = MM_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [REGIDWIDTH-1:0]        cmd_dst,
    input  logic [LOG2_MAT_MUL_SIZE:0]   cmd_a_rows,
    input  logic [LOG2_MAT_MUL_SIZE:0]   cmd_a_cols,
    input  logic [LOG2_MAT_MUL_SIZE:0]   cmd_b_cols,
    input  logic [NUMLANES-1:0]          cmd_vmask,
    input  logic                         abort,
    output logic                         mm_activate,
    output logic [MAT_MUL_SIZE-1:0]      mm_mask_a_rows,
    output logic [MAT_MUL_SIZE-1:0]      mm_mask_a_cols,
    output logic [MAT_MUL_SIZE-1:0]      mm_mask_b_rows,
    output logic [MAT_MUL_SIZE-1:0]      mm_mask_b_cols,
    input  logic                         mm_in_progress,
    input  logic                         mm_data_avail,
    output logic                         wb_we,
    output logic [REGIDWIDTH-1:0]        wb_dst,
    output logic [NUMLANES-1:0]          wb_mask,
    output logic                         busy,
    output logic                         cmd_err,
    output logic                         timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [1:0]                     state_q, state_d;
    logic [WD_W-1:0]                wd_q, wd_d;
    logic [LOG2_MAT_MUL_SIZE:0]     row_q, row_d;
    logic [LOG2_MAT_MUL_SIZE:0]     arows_q, arows_d;
    logic [REGIDWIDTH-1:0]          dst_q, dst_d;
    logic [NUMLANES-1:0]            vmask_q, vmask_d;
    logic [MAT_MUL_SIZE-1:0]        mar_q, mar_d, mac_q, mac_d, mbr_q, mbr_d, mbc_q, mbc_d;
    logic [MAT_MUL_SIZE-1:0]        mar_c, mac_c, mbr_c, mbc_c;
    logic                           ready_q, ready_d;
    logic                           we_q, we_d;
    logic [REGIDWIDTH-1:0]          wbdst_q, wbdst_d;
    logic [NUMLANES-1:0]            wbmask_q, wbmask_d;
    logic                           cerr_q, cerr_d;
    logic                           terr_q, terr_d;
    logic                           accept, zero_cmd, active, abort_act;

    matmul_mask_gen u_mask_a_rows (.count_i(cmd_a_rows), .mask_o(mar_c));
    matmul_mask_gen u_mask_a_cols (.count_i(cmd_a_cols), .mask_o(mac_c));
    matmul_mask_gen u_mask_b_rows (.count_i(cmd_a_cols), .mask_o(mbr_c));
    matmul_mask_gen u_mask_b_cols (.count_i(cmd_b_cols), .mask_o(mbc_c));

    assign active    = (state_q != ST_IDLE);
    assign abort_act = abort & active;
    assign accept    = cmd_valid & ready_q & (state_q == ST_IDLE);
    assign zero_cmd  = (cmd_a_rows == '0) | (cmd_a_cols == '0) | (cmd_b_cols == '0);

    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        row_d    = row_q;
        arows_d  = arows_q;
        dst_d    = dst_q;
        vmask_d  = vmask_q;
        mar_d    = mar_q;
        mac_d    = mac_q;
        mbr_d    = mbr_q;
        mbc_d    = mbc_q;
        we_d     = 1'b0;
        wbdst_d  = wbdst_q;
        wbmask_d = wbmask_q;
        cerr_d   = 1'b0;
        terr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (zero_cmd) begin
                        cerr_d = 1'b1;
                    end else begin
                        arows_d = sat_count(cmd_a_rows);
                        dst_d   = cmd_dst;
                        vmask_d = cmd_vmask;
                        mar_d   = mar_c;
                        mac_d   = mac_c;
                        mbr_d   = mbr_c;
                        mbc_d   = mbc_c;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                row_d   = '0;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                wd_d = wd_q + 1'b1;
                if (mm_data_avail) begin
                    state_d = ST_DRAIN;
                end else if (wd_d == WD_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    terr_d  = 1'b1;
                end
            end
            default: begin
                if (!mm_data_avail) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // The row that moves BUSY into DRAIN is written back like any DRAIN row
        if (((state_q == ST_BUSY) || (state_q == ST_DRAIN)) && mm_data_avail
            && (row_q < arows_q)) begin
            we_d     = 1'b1;
            wbdst_d  = dst_q + REGIDWIDTH'(row_q);
            wbmask_d = vmask_q;
            row_d    = row_q + 1'b1;
        end

        if (abort_act) begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
            terr_d  = 1'b0;
        end

        if (active && (state_d == ST_IDLE)) begin
            mar_d = '0;
            mac_d = '0;
            mbr_d = '0;
            mbc_d = '0;
        end
    end

    // Ready only after a full IDLE cycle, so a returning op never overlaps an accept
    assign ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            wd_q     <= '0;
            row_q    <= '0;
            arows_q  <= '0;
            dst_q    <= '0;
            vmask_q  <= '0;
            mar_q    <= '0;
            mac_q    <= '0;
            mbr_q    <= '0;
            mbc_q    <= '0;
            ready_q  <= 1'b1;
            we_q     <= 1'b0;
            wbdst_q  <= '0;
            wbmask_q <= '0;
            cerr_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            row_q    <= row_d;
            arows_q  <= arows_d;
            dst_q    <= dst_d;
            vmask_q  <= vmask_d;
            mar_q    <= mar_d;
            mac_q    <= mac_d;
            mbr_q    <= mbr_d;
            mbc_q    <= mbc_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            wbdst_q  <= wbdst_d;
            wbmask_q <= wbmask_d;
            cerr_q   <= cerr_d;
            terr_q   <= terr_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign mm_activate    = active;
    assign mm_mask_a_rows = mar_q;
    assign mm_mask_a_cols = mac_q;
    assign mm_mask_b_rows = mbr_q;
    assign mm_mask_b_cols = mbc_q;
    assign wb_we          = we_q & ~abort_act;
    assign wb_dst         = wbdst_q;
    assign wb_mask        = wbmask_q;
    assign busy           = active | mm_in_progress;
    assign cmd_err        = cerr_q;
    assign timeout_err    = terr_q;

endmodule

// File: tb/tb_matmul_cmd_ctrl.sv
// tb/tb_matmul_cmd_ctrl.sv - directed self-checking bench for matmul_cmd_ctrl
module tb_matmul_cmd_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_dst;
    logic [3:0] cmd_a_rows, cmd_a_cols, cmd_b_cols;
    logic [7:0] cmd_vmask;
    logic       abort;
    logic       mm_activate;
    logic [7:0] mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols;
    logic       mm_in_progress;
    logic       mm_data_avail;
    logic       wb_we;
    logic [7:0] wb_dst;
    logic [7:0] wb_mask;
    logic       busy;
    logic       cmd_err;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_cmd_ctrl dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dst(cmd_dst),
        .cmd_a_rows(cmd_a_rows), .cmd_a_cols(cmd_a_cols), .cmd_b_cols(cmd_b_cols),
        .cmd_vmask(cmd_vmask), .abort(abort), .mm_activate(mm_activate),
        .mm_mask_a_rows(mm_mask_a_rows), .mm_mask_a_cols(mm_mask_a_cols),
        .mm_mask_b_rows(mm_mask_b_rows), .mm_mask_b_cols(mm_mask_b_cols),
        .mm_in_progress(mm_in_progress), .mm_data_avail(mm_data_avail),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_mask(wb_mask), .busy(busy),
        .cmd_err(cmd_err), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [3:0] ar, ac, bc;
        logic [7:0] e_ar, e_ac, e_br, e_bc;
        logic       e_err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_act", 32'(mm_activate), 0);
        chk("rst_masks", {mm_mask_a_rows, mm_mask_a_cols, mm_mask_b_rows, mm_mask_b_cols}, 0);
        chk("rst_wb", {wb_we, wb_dst, wb_mask}, 0);
        chk("rst_flags", {busy, cmd_err, timeout_err}, 0);
    endtask

    // Called at a negedge with cmd_ready high; returns at the negedge of the ISSUE cycle
    task automatic send_cmd(input logic [7:0] dst, input logic [3:0] ar, input logic [3:0] ac,
                            input logic [3:0] bc, input logic [7:0] vm);
        cmd_valid  = 1'b1;
        cmd_dst    = dst;
        cmd_a_rows = ar;
        cmd_a_cols = ac;
        cmd_b_cols = bc;
        cmd_vmask  = vm;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    // Cycle 0 is the ISSUE cycle; the unit model streams nrows rows from cycle start
    task automatic run_stream(input logic [7:0] dst, input logic [7:0] vm, input int arows,
                              input int start, input int nrows, input int abort_at, input int ncyc);
        int endc, k;
        logic exp_we;
        endc = start + nrows + 1;
        if (abort_at + 1 < endc) endc = abort_at + 1;
        for (int c = 0; c < ncyc; c++) begin
            mm_data_avail = (c >= start) && (c < start + nrows) && (c <= abort_at);
            abort         = (c == abort_at);
            #1;
            k      = c - 1 - start;
            exp_we = (k >= 0) && (k < nrows) && (k < arows) && (c < abort_at);
            chk("stream_we", 32'(wb_we), 32'(exp_we));
            if (exp_we) begin
                chk("stream_dst", 32'(wb_dst), 32'(8'(dst + 8'(k))));
                chk("stream_mask", 32'(wb_mask), 32'(vm));
            end
            chk("stream_act", 32'(mm_activate), 32'(c < endc));
            chk("stream_ready", 32'(cmd_ready), 32'(c > endc));
            @(negedge clk);
        end
        mm_data_avail = 1'b0;
        abort         = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd8,  4'd8, 4'd8,  8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[1] = '{4'd3,  4'd5, 4'd2,  8'h07, 8'h1F, 8'h1F, 8'h03, 1'b0};
        vecs[2] = '{4'd1,  4'd1, 4'd1,  8'h01, 8'h01, 8'h01, 8'h01, 1'b0};
        vecs[3] = '{4'd15, 4'd9, 4'd12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};
        vecs[4] = '{4'd4,  4'd0, 4'd3,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{4'd0,  4'd2, 4'd2,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{4'd2,  4'd3, 4'd0,  8'h00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[7] = '{4'd7,  4'd6, 4'd12, 8'h7F, 8'h3F, 8'h3F, 8'hFF, 1'b0};

        resetn = 1'b0; cmd_valid = 1'b0; cmd_dst = '0; cmd_a_rows = '0; cmd_a_cols = '0;
        cmd_b_cols = '0; cmd_vmask = '0; abort = 1'b0; mm_in_progress = 1'b0; mm_data_avail = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_state();
        resetn = 1'b1;
        @(negedge clk);

        abort = 1'b1;
        #1;
        chk("idle_abort_wb", 32'(wb_we), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", 32'(cmd_ready), 1);
        mm_in_progress = 1'b1;
        #1;
        chk("busy_in_progress", 32'(busy), 1);
        mm_in_progress = 1'b0;
        #1;
        chk("busy_idle", 32'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            send_cmd(8'h00, vecs[i].ar, vecs[i].ac, vecs[i].bc, 8'hFF);
            chk("vec_err", 32'(cmd_err), 32'(vecs[i].e_err));
            chk("vec_act", 32'(mm_activate), 32'(!vecs[i].e_err));
            chk("vec_ready", 32'(cmd_ready), 32'(vecs[i].e_err));
            chk("vec_mask_ar", 32'(mm_mask_a_rows), 32'(vecs[i].e_ar));
            chk("vec_mask_ac", 32'(mm_mask_a_cols), 32'(vecs[i].e_ac));
            chk("vec_mask_br", 32'(mm_mask_b_rows), 32'(vecs[i].e_br));
            chk("vec_mask_bc", 32'(mm_mask_b_cols), 32'(vecs[i].e_bc));
            if (vecs[i].e_err) begin
                @(negedge clk);
                chk("vec_err_pulse_end", 32'(cmd_err), 0);
                chk("vec_err_no_act", 32'(mm_activate), 0);
            end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("vec_abort_act", 32'(mm_activate), 0);
                chk("vec_abort_masks", {mm_mask_a_rows, mm_mask_a_cols}, 0);
                chk("vec_abort_noerr", {cmd_err, timeout_err}, 0);
                chk("vec_ready_low", 32'(cmd_ready), 0);
                @(negedge clk);
                chk("vec_ready_back", 32'(cmd_ready), 1);
            end
        end

        send_cmd(8'h10, 4'd8, 4'd8, 4'd8, 8'hFF);
        run_stream(8'h10, 8'hFF, 8, 8, 8, 1000, 20);

        send_cmd(8'h20, 4'd3, 4'd5, 4'd2, 8'hA5);
        chk("sub_mask_ar", 32'(mm_mask_a_rows), 32'h07);
        run_stream(8'h20, 8'hA5, 3, 3, 8, 1000, 15);

        send_cmd(8'h40, 4'd8, 4'd8, 4'd8, 8'h0F);
        run_stream(8'h40, 8'h0F, 8, 2, 8, 5, 9);

        send_cmd(8'hFE, 4'd4, 4'd4, 4'd4, 8'h81);
        run_stream(8'hFE, 8'h81, 4, 1, 4, 1000, 9);

        send_cmd(8'h30, 4'd8, 4'd8, 4'd8, 8'hFF);
        for (int c = 0; c < 67; c++) begin
            chk("to_err", 32'(timeout_err), 32'(c == 64));
            chk("to_act", 32'(mm_activate), 32'(c < 64));
            chk("to_ready", 32'(cmd_ready), 32'(c > 64));
            @(negedge clk);
        end

        send_cmd(8'h50, 4'd8, 4'd8, 4'd8, 8'hFF);
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        resetn = 1'b0;
        @(negedge clk);
        chk_reset_state();
        resetn = 1'b1;
        @(negedge clk);
        send_cmd(8'h10, 4'd8, 4'd8, 4'd8, 8'h3C);
        run_stream(8'h10, 8'h3C, 8, 8, 8, 1000, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
